qspi_read_scheduler: RTL and testbench

QSPI_READ_SCHEDULER -- requirements
Module: qspi_read_scheduler

---
 rtl/qspi_read_scheduler_if.sv | 54 +++++
 rtl/qspi_read_scheduler.sv | 177 +++++++++++++++++
 tb/tb_qspi_read_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_read_scheduler_if.sv
// Bundle of requester, engine and status signals for the QSPI read scheduler.
// The slave modport is the scheduler side. The master modport is the
// environment side: the requesters plus the read engine.
interface qspi_read_scheduler_if #(
    parameter int unsigned DIE_LOG2 = 25
);
    logic                  req0_valid;
    logic [31:0]           req0_start_addr;
    logic [31:0]           req0_end_addr;
    logic [1:0]            req0_mode;
    logic                  req0_ready;
    logic                  req0_done;
    logic                  req0_err;

    logic                  req1_valid;
    logic [31:0]           req1_start_addr;
    logic [31:0]           req1_end_addr;
    logic [1:0]            req1_mode;
    logic                  req1_ready;
    logic                  req1_done;
    logic                  req1_err;

    logic                  eng_start_flag;
    logic                  eng_switch_die_need;
    logic [1:0]            eng_mode;
    logic [31:0]           eng_start_addr;
    logic [31:0]           eng_end_addr;
    logic                  eng_read_finish;

    logic                  busy;
    logic [31-DIE_LOG2:0]  cur_die;

    modport slave (
        input  req0_valid, req0_start_addr, req0_end_addr, req0_mode,
        input  req1_valid, req1_start_addr, req1_end_addr, req1_mode,
        input  eng_read_finish,
        output req0_ready, req0_done, req0_err,
        output req1_ready, req1_done, req1_err,
        output eng_start_flag, eng_switch_die_need, eng_mode,
        output eng_start_addr, eng_end_addr,
        output busy, cur_die
    );

    modport master (
        output req0_valid, req0_start_addr, req0_end_addr, req0_mode,
        output req1_valid, req1_start_addr, req1_end_addr, req1_mode,
        output eng_read_finish,
        input  req0_ready, req0_done, req0_err,
        input  req1_ready, req1_done, req1_err,
        input  eng_start_flag, eng_switch_die_need, eng_mode,
        input  eng_start_addr, eng_end_addr,
        input  busy, cur_die
    );
endinterface

// File: rtl/qspi_read_scheduler.sv
// QSPI read scheduler. It arbitrates between two requesters and splits each
// read into per-die chunks for the read engine. It also flags a die switch
// and aborts a chunk when the engine does not finish in time.
module qspi_read_scheduler #(
    parameter int unsigned DIE_LOG2    = 25,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1000000
) (
    input  logic                 system_clk,
    input  logic                 system_reset_n,
    qspi_read_scheduler_if.slave bus
);
    localparam int unsigned DIE_W = 32 - DIE_LOG2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       r_state;
    logic [31:0]      r_cur_addr;
    logic [31:0]      r_end_addr;
    logic [31:0]      r_chunk_end;
    logic [1:0]       r_mode;
    logic             r_grant;
    logic             r_last;
    logic             r_err;
    logic             r_die_sw;
    logic             r_die_valid;
    logic [DIE_W-1:0] r_cur_die;
    logic [23:0]      r_timer;

    logic             r_ready0, r_ready1;
    logic             r_done0, r_done1;
    logic             r_err0, r_err1;
    logic             r_eng_start;
    logic             r_eng_sw;
    logic [1:0]       r_eng_mode;
    logic [31:0]      r_eng_start_addr;
    logic [31:0]      r_eng_end_addr;

    logic             w_grant;
    logic [31:0]      w_die_top;
    logic [31:0]      w_chunk_end;
    logic             w_illegal;
    logic             w_die_sw;
    logic             w_timeout;

    // Round-robin pick: on contention the requester not served last wins.
    assign w_grant     = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
    // The last byte of the die that holds cur_addr bounds the chunk.
    assign w_die_top   = {r_cur_addr[31:DIE_LOG2], {DIE_LOG2{1'b1}}};
    assign w_chunk_end = (r_end_addr < w_die_top) ? r_end_addr : w_die_top;
    assign w_illegal   = (r_end_addr < r_cur_addr) || (r_mode == 2'b11);
    assign w_die_sw    = (r_cur_addr[31:DIE_LOG2] != r_cur_die) || !r_die_valid;
    assign w_timeout   = (r_timer == TIMEOUT_CYC - 24'd1);

    assign bus.req0_ready          = r_ready0;
    assign bus.req1_ready          = r_ready1;
    assign bus.req0_done           = r_done0;
    assign bus.req1_done           = r_done1;
    assign bus.req0_err            = r_err0;
    assign bus.req1_err            = r_err1;
    assign bus.eng_start_flag      = r_eng_start;
    assign bus.eng_switch_die_need = r_eng_sw;
    assign bus.eng_mode            = r_eng_mode;
    assign bus.eng_start_addr      = r_eng_start_addr;
    assign bus.eng_end_addr        = r_eng_end_addr;
    assign bus.busy                = (r_state != S_IDLE);
    assign bus.cur_die             = r_cur_die;

    // Scheduler FSM: accept, validate, issue per-die chunks, wait and report.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state          <= S_IDLE;
            r_cur_addr       <= '0;
            r_end_addr       <= '0;
            r_chunk_end      <= '0;
            r_mode           <= '0;
            r_grant          <= 1'b0;
            r_last           <= 1'b1;
            r_err            <= 1'b0;
            r_die_sw         <= 1'b0;
            r_die_valid      <= 1'b1;
            r_cur_die        <= '0;
            r_timer          <= '0;
            r_ready0         <= 1'b0;
            r_ready1         <= 1'b0;
            r_done0          <= 1'b0;
            r_done1          <= 1'b0;
            r_err0           <= 1'b0;
            r_err1           <= 1'b0;
            r_eng_start      <= 1'b0;
            r_eng_sw         <= 1'b0;
            r_eng_mode       <= '0;
            r_eng_start_addr <= '0;
            r_eng_end_addr   <= '0;
        end else begin
            r_ready0 <= 1'b0;
            r_ready1 <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        r_grant    <= w_grant;
                        r_ready0   <= ~w_grant;
                        r_ready1   <= w_grant;
                        r_cur_addr <= w_grant ? bus.req1_start_addr : bus.req0_start_addr;
                        r_end_addr <= w_grant ? bus.req1_end_addr : bus.req0_end_addr;
                        r_mode     <= w_grant ? bus.req1_mode : bus.req0_mode;
                        r_err      <= 1'b0;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_chunk_end <= w_chunk_end;
                        r_die_sw    <= w_die_sw;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_eng_start_addr <= r_cur_addr;
                    r_eng_end_addr   <= r_chunk_end;
                    r_eng_mode       <= r_mode;
                    r_eng_sw         <= r_die_sw;
                    r_eng_start      <= 1'b1;
                    r_cur_die        <= r_cur_addr[31:DIE_LOG2];
                    r_die_valid      <= 1'b1;
                    r_timer          <= '0;
                    r_state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.eng_read_finish) begin
                        r_eng_start <= 1'b0;
                        r_state     <= S_GAP;
                    end else if (w_timeout) begin
                        // Die state is unknown after an abort; force a reselect next time.
                        r_eng_start <= 1'b0;
                        r_die_valid <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                S_GAP: begin
                    if (!bus.eng_read_finish) begin
                        if (r_chunk_end == r_end_addr) begin
                            r_state <= S_DONE;
                        end else begin
                            // Advance only when more bytes remain, so an end of all ones cannot wrap.
                            r_cur_addr <= r_chunk_end + 32'd1;
                            r_state    <= S_CHECK;
                        end
                    end
                end
                S_DONE: begin
                    r_done0 <= ~r_grant;
                    r_done1 <= r_grant;
                    r_err0  <= ~r_grant & r_err;
                    r_err1  <= r_grant & r_err;
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_read_scheduler.sv
// Scoreboard bench for qspi_read_scheduler: expected chunks and completions
// are queued when a request is driven and checked as the DUT produces them.
module tb_qspi_read_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    qspi_read_scheduler_if #(.DIE_LOG2(25)) ifa ();
    qspi_read_scheduler_if #(.DIE_LOG2(25)) ift ();

    qspi_read_scheduler #(.DIE_LOG2(25), .TIMEOUT_CYC(24'd1000000)) dut (
        .system_clk(clk), .system_reset_n(rst_n), .bus(ifa));
    qspi_read_scheduler #(.DIE_LOG2(25), .TIMEOUT_CYC(24'd50)) dut_to (
        .system_clk(clk), .system_reset_n(rst_n), .bus(ift));

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] e;
        logic [1:0]  m;
        logic        sw;
    } chunk_t;
    typedef struct packed {
        logic id;
        logic err;
    } done_t;

    chunk_t exp_chunk[$];
    done_t  exp_done[$];
    done_t  d_exp;
    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_flag = 0;
    int eng_lat = 10;
    logic [6:0] m_die = 7'd0;
    logic       m_dv = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: split the range at 32 MB die boundaries.
    task automatic push_req(input logic id, input logic [31:0] s, input logic [31:0] e,
                            input logic [1:0] m);
        logic [31:0] a;
        logic [31:0] top;
        logic [31:0] ce;
        logic [6:0]  die;
        chunk_t      c;
        if (m == 2'b11 || e < s) begin
            exp_done.push_back('{id: id, err: 1'b1});
            return;
        end
        a = s;
        forever begin
            die  = a[31:25];
            top  = {die, 25'h1FFFFFF};
            ce   = (e < top) ? e : top;
            c.s  = a;
            c.e  = ce;
            c.m  = m;
            c.sw = (die != m_die) || !m_dv;
            exp_chunk.push_back(c);
            m_die = die;
            m_dv  = 1'b1;
            if (ce == e) break;
            a = ce + 32'd1;
        end
        exp_done.push_back('{id: id, err: 1'b0});
    endtask

    task automatic drive(input logic id, input logic [31:0] s, input logic [31:0] e,
                         input logic [1:0] m, input logic v);
        if (id) begin
            ifa.req1_valid = v; ifa.req1_start_addr = s; ifa.req1_end_addr = e; ifa.req1_mode = m;
        end else begin
            ifa.req0_valid = v; ifa.req0_start_addr = s; ifa.req0_end_addr = e; ifa.req0_mode = m;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_die = 7'd0;
        m_dv  = 1'b1;
        exp_chunk.delete();
        exp_done.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One request on ifa; lat is the cycle count from the ready pulse to the done pulse.
    task automatic do_req(input logic id, input logic [31:0] s, input logic [31:0] e,
                          input logic [1:0] m, output int lat);
        int cyc;
        push_req(id, s, e, m);
        drive(id, s, e, m, 1'b1);
        cyc = 0;
        while (!(ifa.req0_ready || ifa.req1_ready) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("ready_seen", 64'(cyc < 20), 1);
        chk("ready_id", {ifa.req1_ready, ifa.req0_ready}, id ? 2'b10 : 2'b01);
        // Scribble the inputs after acceptance; the request in flight must not change.
        drive(id, 32'hDEAD0000, 32'h0, 2'b11, 1'b0);
        cyc = 0;
        while (!(ifa.req0_done || ifa.req1_done) && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
        end
        chk("done_seen", 64'(cyc < 5000), 1);
        lat = cyc;
        @(posedge clk); #1;
    endtask

    // Engine model for ifa: check each issued chunk, finish after eng_lat cycles.
    initial begin
        chunk_t c;
        chunk_t got;
        ifa.eng_read_finish = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ifa.eng_start_flag) begin
                n_flag++;
                got.s  = ifa.eng_start_addr;
                got.e  = ifa.eng_end_addr;
                got.m  = ifa.eng_mode;
                got.sw = ifa.eng_switch_die_need;
                if (exp_chunk.size() == 0) begin
                    chk("unexpected_chunk", 1, 0);
                end else begin
                    c = exp_chunk.pop_front();
                    chk("chunk_start", got.s, c.s);
                    chk("chunk_end", got.e, c.e);
                    chk("chunk_mode", got.m, c.m);
                    chk("chunk_switch", got.sw, c.sw);
                end
                for (int i = 0; i < eng_lat && ifa.eng_start_flag; i++) begin
                    @(posedge clk); #1;
                end
                if (ifa.eng_start_flag)
                    chk("eng_hold", {ifa.eng_start_addr, ifa.eng_end_addr}, {got.s, got.e});
                ifa.eng_read_finish = 1'b1;
                for (int i = 0; i < 8 && ifa.eng_start_flag; i++) begin
                    @(posedge clk); #1;
                end
                chk("flag_drop", ifa.eng_start_flag, 0);
                ifa.eng_read_finish = 1'b0;
            end
        end
    end

    // Completion monitor for ifa.
    always @(negedge clk) begin
        if (ifa.req0_done || ifa.req1_done) begin
            n_done++;
            chk("done_single", {ifa.req1_done, ifa.req0_done} == 2'b11, 0);
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                d_exp = exp_done.pop_front();
                chk("done_id", ifa.req1_done, d_exp.id);
                chk("done_err", d_exp.id ? ifa.req1_err : ifa.req0_err, d_exp.err);
                chk("err_other", d_exp.id ? ifa.req0_err : ifa.req1_err, 0);
            end
        end
    end

    initial begin
        int lat;
        int n0;
        int cyc;
        int cnt;
        ifa.req0_valid = 0; ifa.req0_start_addr = 0; ifa.req0_end_addr = 0; ifa.req0_mode = 0;
        ifa.req1_valid = 0; ifa.req1_start_addr = 0; ifa.req1_end_addr = 0; ifa.req1_mode = 0;
        ift.req0_valid = 0; ift.req0_start_addr = 0; ift.req0_end_addr = 0; ift.req0_mode = 0;
        ift.req1_valid = 0; ift.req1_start_addr = 0; ift.req1_end_addr = 0; ift.req1_mode = 0;
        ift.eng_read_finish = 1'b0;
        #2;
        do_reset();
        chk("rst_ctl", {ifa.busy, ifa.eng_start_flag, ifa.req0_ready, ifa.req1_ready,
                        ifa.req0_done, ifa.req1_done}, 0);
        chk("rst_cur_die", ifa.cur_die, 0);

        // Single-die read, slow engine.
        eng_lat = 200;
        do_req(1'b0, 32'h000000BB, 32'h000000BE, 2'b00, lat);
        chk("single_lat", 64'(lat > 200), 1);

        // Die crossing.
        eng_lat = 20;
        do_req(1'b1, 32'h01FFFFF0, 32'h02000003, 2'b00, lat);
        chk("cross_cur_die", ifa.cur_die, 1);

        // Read ending at the top of the address space.
        do_req(1'b0, 32'hFFFFFFF0, 32'hFFFFFFFF, 2'b10, lat);
        chk("top_cur_die", ifa.cur_die, 7'h7F);
        chk("top_idle", ifa.busy, 0);

        // Arbitration: both held valid, grants must alternate starting at req0.
        do_reset();
        eng_lat = 5;
        n0 = n_done;
        for (int k = 0; k < 4; k++) push_req(1'(k % 2), 32'hCC, 32'hCF, 2'b10);
        drive(1'b0, 32'hCC, 32'hCF, 2'b10, 1'b1);
        drive(1'b1, 32'hCC, 32'hCF, 2'b10, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (!(ifa.req0_ready || ifa.req1_ready) && cyc < 500) begin
                @(posedge clk); #1; cyc++;
            end
            chk("rr_seen", 64'(cyc < 500), 1);
            chk("rr_grant", {ifa.req1_ready, ifa.req0_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 2'b00, 1'b0);
        cyc = 0;
        while (n_done < n0 + 4 && cyc < 2000) begin
            @(posedge clk); #1; cyc++;
        end
        chk("rr_done_count", n_done - n0, 4);

        // Illegal requests never reach the engine.
        n0 = n_flag;
        do_req(1'b0, 32'h100, 32'h1FF, 2'b11, lat);
        chk("ill_mode_lat", 64'(lat <= 3), 1);
        do_req(1'b1, 32'h20, 32'h10, 2'b00, lat);
        chk("ill_range_lat", 64'(lat <= 3), 1);
        chk("ill_no_flag", n_flag - n0, 0);

        // Reset while waiting on a dual-mode chunk.
        eng_lat = 200;
        push_req(1'b0, 32'h1000, 32'h10FF, 2'b01);
        drive(1'b0, 32'h1000, 32'h10FF, 2'b01, 1'b1);
        cyc = 0;
        while (!ifa.req0_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        cyc = 0;
        while (!ifa.eng_start_flag && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk("mid_flag", ifa.eng_start_flag, 1);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_eng_addr", {ifa.eng_start_addr, ifa.eng_end_addr}, 0);
        chk("rst_mid_ctl", {ifa.eng_start_flag, ifa.eng_switch_die_need, ifa.eng_mode, ifa.busy,
                            ifa.req0_ready, ifa.req1_ready, ifa.req0_done, ifa.req1_done,
                            ifa.req0_err, ifa.req1_err}, 0);
        chk("rst_mid_cur_die", ifa.cur_die, 0);
        m_die = 7'd0;
        m_dv  = 1'b1;
        exp_chunk.delete();
        exp_done.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = n_done;
        repeat (300) @(posedge clk);
        #1;
        chk("rst_no_done", n_done - n0, 0);

        // Timeout on the second instance, whose engine never finishes.
        for (int r = 0; r < 2; r++) begin
            ift.req0_start_addr = 32'h100;
            ift.req0_end_addr   = 32'h10F;
            ift.req0_mode       = 2'b00;
            ift.req0_valid      = 1'b1;
            cyc = 0;
            while (!ift.req0_ready && cyc < 20) begin
                @(posedge clk); #1; cyc++;
            end
            chk("to_ready", ift.req0_ready, 1);
            ift.req0_valid = 1'b0;
            cyc = 0;
            while (!ift.eng_start_flag && cyc < 20) begin
                @(posedge clk); #1; cyc++;
            end
            chk("to_switch", ift.eng_switch_die_need, (r == 1) ? 1 : 0);
            cnt = 0;
            while (ift.eng_start_flag && cnt < 200) begin
                cnt++;
                @(posedge clk); #1;
            end
            chk("to_flag_cycles", cnt, 50);
            cyc = 0;
            while (!ift.req0_done && cyc < 10) begin
                @(posedge clk); #1; cyc++;
            end
            chk("to_done", ift.req0_done, 1);
            chk("to_err", ift.req0_err, 1);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
